// File: rtl/sort_check_pkg.sv
// Shared types for the sorted-array checker: scan FSM states and mode encodings.
package sort_check_pkg;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_scan = 2'd1,
        st_done = 2'd2
    } state_t;

    localparam logic MODE_ASC  = 1'b0;
    localparam logic MODE_DESC = 1'b1;

endpackage

// File: rtl/sort_check_regfile.sv
// DEPTH x WIDTH register file: two combinational read ports, one clocked write
// port, every entry cleared by the asynchronous active-low reset.
module sort_check_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);

    logic [WIDTH-1:0] r [DEPTH];

    // storage: clear on reset, single write port otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= '0;
            end
        end else if (wr_en) begin
            r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = r[rd_addr_a];
    assign rd_data_b = r[rd_addr_b];

endmodule

// File: rtl/array_sort_checker.sv
// Sorted-array checker: scans a wrap-around run of register file words and
// reports whether it is monotonic (ascending or descending) and where the
// first inversion sits.
// Optional feature macro: SORT_CHECK_COUNT_EN -- full-length scan plus a
// saturating inversion counter on port inv_count.
//
// state   | meaning
// --------+------------------------------------------------------------
// st_idle | waiting for go; register file writable
// st_scan | comparing one adjacent pair per cycle; writes are dropped
// st_done | one-cycle done pulse, verdict registers already settled
module array_sort_checker
    import sort_check_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             go,
    input  logic [AW-1:0]    array,
    input  logic [AW:0]      length,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             sorted,
    output logic             inversion_found,
    output logic             zero_length_array,
    output logic [AW-1:0]    first_inv_index
`ifdef SORT_CHECK_COUNT_EN
    ,
    output logic [AW:0]      inv_count
`endif
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    base_q;
    logic [AW-1:0]    idx_q;
    logic [AW:0]      len_q;
    logic             mode_q;
    logic [AW:0]      len_clamp;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic             pair_inv;
    logic             last_pair;
    logic             scan_exit;

    sort_check_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) rf (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en & ~busy),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (addr_a),
        .rd_data_a (word_a),
        .rd_addr_b (addr_b),
        .rd_data_b (word_b)
    );

    assign len_clamp = (length > DEPTH_W) ? DEPTH_W : length;

    // Address arithmetic is AW bits wide, so the modulo-DEPTH wrap is free.
    assign addr_b    = base_q + idx_q;
    assign addr_a    = addr_b - AW'(1);
    assign pair_inv  = (mode_q == MODE_DESC) ? (word_a < word_b) : (word_a > word_b);
    assign last_pair = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

`ifdef SORT_CHECK_COUNT_EN
    assign scan_exit = last_pair;
`else
    assign scan_exit = last_pair | pair_inv;
`endif

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: begin
                if (go) begin
                    state_d = (len_clamp <= (AW+1)'(1)) ? st_done : st_scan;
                end
            end
            st_scan: begin
                if (scan_exit) begin
                    state_d = st_done;
                end
            end
            st_done: state_d = st_idle;
            default: state_d = st_idle;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy = (state_q == st_scan);
        done = (state_q == st_done);
    end

    // run parameters, scan index and verdict registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q            <= '0;
            idx_q             <= '0;
            len_q             <= '0;
            mode_q            <= MODE_ASC;
            sorted            <= 1'b0;
            inversion_found   <= 1'b0;
            zero_length_array <= 1'b0;
            first_inv_index   <= '0;
`ifdef SORT_CHECK_COUNT_EN
            inv_count         <= '0;
`endif
        end else begin
            case (state_q)
                st_idle: begin
                    if (go) begin
                        base_q            <= array;
                        len_q             <= len_clamp;
                        mode_q            <= mode;
                        idx_q             <= AW'(1);
                        // Runs of 0 or 1 words are trivially sorted.
                        sorted            <= (len_clamp <= (AW+1)'(1));
                        inversion_found   <= 1'b0;
                        zero_length_array <= (length == '0);
                        first_inv_index   <= '0;
`ifdef SORT_CHECK_COUNT_EN
                        inv_count         <= '0;
`endif
                    end
                end
                st_scan: begin
                    if (pair_inv && !inversion_found) begin
                        first_inv_index <= idx_q;
                        inversion_found <= 1'b1;
                    end
`ifdef SORT_CHECK_COUNT_EN
                    if (pair_inv && (inv_count != '1)) begin
                        inv_count <= inv_count + (AW+1)'(1);
                    end
`endif
                    if (scan_exit) begin
                        sorted <= !(inversion_found | pair_inv);
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_sort_checker.sv
// Self-checking bench for array_sort_checker: directed cases plus randomized
// runs compared against a pair-by-pair reference model of the register file.
module tb_array_sort_checker;
    import sort_check_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             go = 1'b0;
    logic [AW-1:0]    array = '0;
    logic [AW:0]      length = '0;
    logic             mode = 1'b0;
    logic             busy;
    logic             done;
    logic             sorted;
    logic             inversion_found;
    logic             zero_length_array;
    logic [AW-1:0]    first_inv_index;
`ifdef SORT_CHECK_COUNT_EN
    logic [AW:0]      inv_count;
`endif

    int unsigned      mem [DEPTH];
    int               errors = 0;
    int               checks = 0;

    always #5 clock = ~clock;

    array_sort_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) circuit (
        .clock             (clock),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .go                (go),
        .array             (array),
        .length            (length),
        .mode              (mode),
        .busy              (busy),
        .done              (done),
        .sorted            (sorted),
        .inversion_found   (inversion_found),
        .zero_length_array (zero_length_array),
        .first_inv_index   (first_inv_index)
`ifdef SORT_CHECK_COUNT_EN
        ,
        .inv_count         (inv_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: walk every adjacent pair of the run using modulo indexing.
    task automatic model(input int base, input int len, input int md,
                         output int lat, output int srt, output int inv,
                         output int fst, output int zr, output int cnt);
        int l;
        int a;
        int b;
        l   = (len > DEPTH) ? DEPTH : len;
        zr  = (len == 0);
        inv = 0;
        fst = 0;
        cnt = 0;
        for (int i = 1; i < l; i++) begin
            a = mem[(base + i - 1) % DEPTH];
            b = mem[(base + i) % DEPTH];
            if ((md == 0 && a > b) || (md == 1 && a < b)) begin
                cnt++;
                if (!inv) begin
                    inv = 1;
                    fst = i;
                end
            end
        end
        srt = !inv;
`ifdef SORT_CHECK_COUNT_EN
        lat = (l <= 1) ? 0 : l - 1;
`else
        lat = (l <= 1) ? 0 : (inv ? fst : l - 1);
`endif
    endtask

    task automatic wr(input int addr, input int unsigned data);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
        mem[addr % DEPTH] = data;
    endtask

    // One check run; hold_go keeps go asserted through the scan, bw_addr >= 0
    // attempts a write to that address while busy.
    task automatic run(input string tag, input int base, input int len, input int md,
                       input bit hold_go, input int bw_addr);
        int lat, srt, inv, fst, zr, cnt, cyc;
        model(base, len, md, lat, srt, inv, fst, zr, cnt);
        @(negedge clock);
        array  = AW'(base);
        length = (AW+1)'(len);
        mode   = md[0];
        go     = 1'b1;
        @(posedge clock);
        #1;
        if (!hold_go) go = 1'b0;
        chk({tag, "_busy"}, busy, lat > 0);
        if (bw_addr >= 0) begin
            wr_en   = 1'b1;
            wr_addr = AW'(bw_addr);
            wr_data = ~mem[bw_addr];
        end
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clock);
            #1;
            wr_en = 1'b0;
            cyc++;
        end
        go = 1'b0;
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_sorted"}, sorted, srt);
        chk({tag, "_inv"}, inversion_found, inv);
        chk({tag, "_first"}, first_inv_index, fst);
        chk({tag, "_zero"}, zero_length_array, zr);
`ifdef SORT_CHECK_COUNT_EN
        chk({tag, "_cnt"}, inv_count, cnt);
`endif
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, sorted, srt);
        if (bw_addr >= 0) chk({tag, "_wrdrop"}, circuit.rf.r[bw_addr], mem[bw_addr]);
    endtask

    initial begin
        int base, len, md, p, v, l;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sorted", sorted, 0);
        chk("rst_zero", zero_length_array, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr(i, i);
        run("asc_base11", 11, 5, 0, 0, -1);

        wr(2, 1); wr(3, 2); wr(4, 3); wr(5, 2); wr(6, 5);
        run("inv_at3", 2, 5, 0, 0, -1);

        wr(7, 11); wr(8, 10); wr(9, 9); wr(10, 8); wr(11, 7);
        run("desc_data_asc", 7, 5, 0, 0, -1);
        run("desc_data_desc", 7, 5, 1, 0, -1);

        wr(30, 1); wr(31, 2); wr(0, 3); wr(1, 4);
        run("wrap_ok", 30, 4, 0, 0, -1);
        wr(0, 0);
        run("wrap_inv", 30, 4, 0, 0, -1);

        run("len0", 9, 0, 0, 0, -1);
        run("len1", 9, 1, 1, 0, -1);
        run("len_clamp", 12, 40, 0, 0, -1);
        run("len_full", 13, 32, 0, 0, -1);

        for (int i = 0; i < DEPTH; i++) wr(i, 100 + i);
        run("go_held", 0, 32, 0, 1, -1);
        run("wr_busy", 0, 32, 0, 0, 20);

        // asynchronous reset in the middle of a long scan
        @(negedge clock);
        array = '0; length = (AW+1)'(32); mode = 1'b0; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sorted", sorted, 0);
        chk("arst_inv", inversion_found, 0);
        chk("arst_first", first_inv_index, 0);
        chk("arst_state", 32'(circuit.state_q), 32'(st_idle));
        chk("arst_rf", circuit.rf.r[7], 0);
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 25; n++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 40);
            md   = $urandom_range(0, 1);
            p    = $urandom_range(0, 2);
            l    = (len > DEPTH) ? DEPTH : len;
            if (p != 1) begin
                v = (md == 0) ? $urandom_range(0, 50) : 1000;
                for (int k = 0; k < l; k++) begin
                    wr((base + k) % DEPTH, v);
                    v = (md == 0) ? v + $urandom_range(0, 2) : v - $urandom_range(0, 2);
                end
            end
            if (p != 0) begin
                for (int k = 0; k < 3; k++) wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 1100));
            end
            run("rand", base, len, md, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
